// File: rtl/shift_arbiter.sv
// Two-port arbiter/sequencer in front of the shared combinational BETA shift unit.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; default build is fixed priority (port 0 wins).
module shift_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_sfn,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_sfn,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_b,
    output logic [1:0]  sh_sfn,
    output logic [31:0] sh_a,
    output logic [4:0]  sh_b,
    input  logic [31:0] sh_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_y,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  sfn_q, sfn_d;
    logic [31:0] a_q, a_d;
    logic [4:0]  b_q, b_d;
    logic        id_q, id_d;
    logic [31:0] rsp_y_q, rsp_y_d;
    logic        grant0, grant1;

`ifdef SHIFT_ARB_RR_EN
    logic        last_q, last_d;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        sfn_d      = sfn_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_y_d    = rsp_y_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
`ifdef SHIFT_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                // Ready is masked by reset so outputs sit at their reset values while rst_n is low.
                req0_ready = rst_n && grant0;
                req1_ready = rst_n && grant1;
                if (grant0 || grant1) begin
                    sfn_d   = grant1 ? req1_sfn : req0_sfn;
                    a_d     = grant1 ? req1_a   : req0_a;
                    b_d     = grant1 ? req1_b   : req0_b;
                    id_d    = grant1;
`ifdef SHIFT_ARB_RR_EN
                    last_d  = grant1;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_y_d = sh_y;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sfn_q   <= 2'b00;
            a_q     <= 32'h0;
            b_q     <= 5'd0;
            id_q    <= 1'b0;
            rsp_y_q <= 32'h0;
        end else begin
            state_q <= state_d;
            sfn_q   <= sfn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            rsp_y_q <= rsp_y_d;
        end
    end

`ifdef SHIFT_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign sh_sfn = sfn_q;
    assign sh_a   = a_q;
    assign sh_b   = b_q;
    assign rsp_id = id_q;
    assign rsp_y  = rsp_y_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencing and arbitration controller that shares the single combinational BETA shift unit between two requesters, e.g. the ALU issue path (port 0) and a multi-cycle helper such as a multiply/divide sequencer (port 1). It accepts one shift operation at a time over a valid/ready handshake and drives registered operands into the shift unit. It captures the result into a holding register and returns it with the requester ID over a valid/ready response channel. The shift unit itself remains purely combinational and sits outside this block.

## Interface
- No parameters. Data width fixed at 32, shift amount 5 bits, function code 2 bits.
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid / req1_valid  input  1  requester has an operation pending
- req0_ready / req1_ready  output  1  operation accepted this cycle (valid & ready)
- req0_sfn / req1_sfn  input  2  function: 00 SHL, 01 SHR logical, 11 SRA, 10 illegal
- req0_a / req1_a  input  32  operand to shift
- req0_b / req1_b  input  5  shift amount
- sh_sfn  output  2  function code to shift unit
- sh_a  output  32  operand to shift unit
- sh_b  output  5  shift amount to shift unit
- sh_y  input  32  combinational result from shift unit
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result this cycle
- rsp_id  output  1  requester that issued the result
- rsp_y  output  32  result
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, select a winner and assert its reqN_ready combinationally in the same cycle.
  - Latch the winner's sfn/a/b into operand registers and its index into id_q, then go to EXEC.
  - The loser's ready stays low, and the loser keeps valid and operands stable.
- EXEC: sh_* are driven from the operand registers. Capture sh_y into rsp_y and go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_y and rsp_id are held stable until rsp_valid & rsp_ready.
  - On acceptance, go to IDLE.
  - No new request is granted in the accepting cycle.
- reqN_ready is only ever high in IDLE, for at most one port.
- sh_sfn/sh_a/sh_b always reflect the operand registers, never the raw request inputs.
- Illegal sfn 10 is passed through unchanged. The shift unit returns 0, and the block reports rsp_y=0 with no error flag.
- Arbitration is fixed priority or round-robin, per Configuration.
- Reset mid-operation: the in-flight transaction is dropped, the FSM returns to IDLE, and no response is issued.

## Timing
- Reset values:
  - req0_ready=0, req1_ready=0, rsp_valid=0, busy=0
  - rsp_id=0, rsp_y=0
  - sh_sfn=0, sh_a=0, sh_b=0
  - FSM=IDLE
  - round-robin pointer last=1, so port 0 wins the first tie
- Latency: handshake in cycle T puts EXEC in T+1, and rsp_valid rises at T+2.
- With rsp_ready held high, the response is accepted in T+2, IDLE is reached in T+3, and the next grant can occur in T+3. Peak throughput is one operation per 3 cycles.
- Backpressure: rsp_valid holds indefinitely while rsp_ready=0. All other requesters stall with ready=0.
- A requester may drop valid before being granted; no state is affected.

## Configuration
- SHIFT_ARB_RR_EN defined:
  - Round-robin. When both ports are valid in IDLE, grant the port that is not `last`.
  - `last` updates to the granted index on every grant.
  - A single valid port is always granted.
- SHIFT_ARB_RR_EN undefined:
  - Fixed priority. Port 0 always wins ties.
  - The `last` register is absent, and port 1 may starve.

## Test plan
- Single op, port 0: sfn=00, a=0x0000_0001, b=4, rsp_ready=1 -> req0_ready high in the handshake cycle; rsp_valid two cycles later with rsp_y=0x0000_0010, rsp_id=0.
- SRA via port 1: sfn=11, a=0x8000_0000, b=31 -> rsp_y=0xFFFF_FFFF, rsp_id=1. Then sfn=01 with the same operands -> rsp_y=0x0000_0001.
- Contention, both valid continuously, 4 ops:
  - With SHIFT_ARB_RR_EN: grants alternate 0,1,0,1.
  - Without SHIFT_ARB_RR_EN: all 4 go to port 0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_y/rsp_id stable, both reqN_ready=0, busy=1. Releasing rsp_ready -> acceptance, then IDLE next cycle.
- Illegal op: sfn=10, a=0xDEAD_BEEF, b=3 -> rsp_y=0x0000_0000, normal handshake timing.
- Reset in EXEC: assert rst_n=0 -> all outputs go to their reset values asynchronously. After release, no rsp_valid appears, and the next request is served normally.
